reg_file_sweep: RTL and testbench
=================================

Name: reg_file_sweep

Overview:
Parametrised register file for the datapath. It generalises the single clearable 32-bit register into DEPTH registers of WIDTH bits. It has one synchronous write port and two combinational read ports, an optional hardwired-zero R0, and optional write-to-read bypass. A sequential bulk-clear engine zeroes every register, one per cycle, without asserting reset.

Parameters:
WIDTH, 32, data width of each register
DEPTH, 16, number of registers; legal values 2..64
ADDR_W, $clog2(DEPTH), address width; derived, not overridden
R0_ZERO, 1, 1 = register 0 always reads 0 and ignores writes
BYPASS, 1, 1 = an accepted same-cycle write is forwarded to matching read ports

Ports:
clk  input  1  system clock; all state updates on posedge
clr  input  1  asynchronous, active-low reset
wr_en  input  1  write request for the current cycle
wr_addr  input  ADDR_W  write register index
wr_data  input  WIDTH  write data
rd_addr_a  input  ADDR_W  read port A index
rd_data_a  output  WIDTH  read port A data, combinational
rd_addr_b  input  ADDR_W  read port B index
rd_data_b  output  WIDTH  read port B data, combinational
bulk_clr_req  input  1  single-cycle request to start a sweep clear
busy  output  1  high while the sweep is in progress
wr_drop  output  1  registered pulse: the previous cycle's write was rejected

Behaviour:
- Reset (clr=0, asynchronous):
  - all registers = 0
  - FSM = IDLE, sweep pointer = 0
  - busy = 0, wr_drop = 0
  - takes effect immediately, including mid-sweep
- Write acceptance: a write is accepted at a posedge when all of the following hold:
  - wr_en = 1
  - FSM = IDLE
  - wr_addr < DEPTH
  - not (R0_ZERO = 1 and wr_addr = 0)
- Accepted write: mem[wr_addr] <= wr_data. Write-to-stored latency is 1 cycle.
- Rejected write: wr_en = 1 with any acceptance condition failing.
  - mem is unchanged
  - wr_drop = 1 for exactly the next cycle
  - a rejected write to R0 when R0_ZERO = 1 is the one exception: it does NOT pulse wr_drop, because it is architecturally legal
- Reads (combinational, both ports independent):
  - rd_addr >= DEPTH -> 0
  - R0_ZERO = 1 and rd_addr = 0 -> 0
  - BYPASS = 1, write accepted this cycle, and rd_addr = wr_addr -> wr_data
  - otherwise mem[rd_addr]
  - with BYPASS = 0, the old value is returned until the posedge
- FSM states: IDLE, SWEEP
  - IDLE -> SWEEP on posedge with bulk_clr_req = 1. Pointer loads 0 and busy goes 1 the same edge.
  - In SWEEP, each posedge: mem[ptr] <= 0 and ptr <= ptr + 1.
  - SWEEP -> IDLE on the edge that clears DEPTH-1; busy falls on that edge.
  - busy is high for exactly DEPTH cycles.
- Simultaneous events:
  - bulk_clr_req and wr_en in the same IDLE cycle: the write is accepted first, then the sweep starts. The written value is later cleared by the sweep.
  - wr_en during SWEEP: rejected, wr_drop pulses, the write is not queued.
  - bulk_clr_req during SWEEP: ignored; the sweep is not restarted.
  - Reads during SWEEP return the current stored value; entries already swept read 0.
  - ptr wrap: ptr never exceeds DEPTH-1; no wrap-around occurs.

Decomposition:
- Shared package reg_file_pkg:
  - FSM state enum (IDLE, SWEEP)
  - default WIDTH/DEPTH constants
  - the R0 index constant
- One sub-module, reg_file_read_port: address range check, R0 masking and the bypass mux. It is instantiated twice, for ports A and B.
- Storage, write acceptance and the sweep FSM stay in the top module.

Test Plan:
- Reset then write 7 to R3 -> rd_data_a(R3) = 7 one cycle later; wr_drop = 0.
- BYPASS = 1: wr_en, wr_addr = 5, wr_data = 56, rd_addr_b = 5 in the same cycle -> rd_data_b = 56 before the edge. BYPASS = 0 -> the old value until the edge.
- R0_ZERO = 1: write 15 to R0 -> reads of R0 stay 0 and wr_drop stays 0. Write to address DEPTH (out of range) -> wr_drop pulses 1 cycle.
- Fill all registers with i+1, pulse bulk_clr_req:
  - busy is high exactly 16 cycles
  - after cycle k, R0..Rk read 0 and Rk+1.. keep i+1
  - all registers read 0 at the end
- Write attempted mid-sweep -> rejected, wr_drop = 1; value not present after the sweep. Second bulk_clr_req mid-sweep -> busy length unchanged.
- Assert clr low mid-sweep (after 5 cycles) -> busy = 0 immediately, all registers read 0, FSM accepts a new write on the first edge after release.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and constants for the sweep-clearable register file.
package reg_file_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 16;
   localparam int R0_IDX    = 0;

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: range check, R0 masking and write bypass.
module reg_file_read_port
   import reg_file_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int ADDR_W  = $clog2(DEPTH),
   parameter int R0_ZERO = 1,
   parameter int BYPASS  = 1
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  stored,
   input  logic              wr_fire,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   output logic [WIDTH-1:0]  data
);

   logic in_range;
   logic is_r0;

   assign in_range = int'(addr) < DEPTH;
   assign is_r0    = (R0_ZERO != 0) && (addr == ADDR_W'(R0_IDX));

   // Masking wins over bypass so a forwarded write can never leak into R0.
   always_comb begin
      data = stored;
      if ((BYPASS != 0) && wr_fire && (addr == wr_addr)) begin
         data = wr_data;
      end
      if (is_r0 || !in_range) begin
         data = '0;
      end
   end

endmodule

// File: rtl/reg_file_sweep.sv
// DEPTH x WIDTH register file with one write port, two read ports and a
// one-register-per-cycle bulk clear engine that runs without reset.
module reg_file_sweep
   import reg_file_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int ADDR_W  = $clog2(DEPTH),
   parameter int R0_ZERO = 1,
   parameter int BYPASS  = 1
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [WIDTH-1:0]  rd_data_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [WIDTH-1:0]  rd_data_b,
   input  logic              bulk_clr_req,
   output logic              busy,
   output logic              wr_drop,
   output state_t            fsm_state
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   logic [WIDTH-1:0]  mem [DEPTH];
   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] ptr_next;
   logic              idle;
   logic              wr_in_range;
   logic              wr_is_r0;
   logic              wr_fire;
   logic              drop_next;

   assign idle        = (state == IDLE);
   assign wr_in_range = int'(wr_addr) < DEPTH;
   assign wr_is_r0    = (R0_ZERO != 0) && (wr_addr == ADDR_W'(R0_IDX));
   assign wr_fire     = wr_en && idle && wr_in_range && !wr_is_r0;
   // A write to a hardwired R0 while idle is legal, so it is not a drop.
   assign drop_next   = wr_en && !wr_fire && !(wr_is_r0 && idle);

   assign busy      = (state == SWEEP);
   assign fsm_state = state;

   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      case (state)
         IDLE: begin
            if (bulk_clr_req) begin
               state_next = SWEEP;
               ptr_next   = '0;
            end
         end
         SWEEP: begin
            if (ptr == LAST) begin
               state_next = IDLE;
               ptr_next   = '0;
            end else begin
               ptr_next = ptr + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            ptr_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state   <= IDLE;
         ptr     <= '0;
         wr_drop <= 1'b0;
      end else begin
         state   <= state_next;
         ptr     <= ptr_next;
         wr_drop <= drop_next;
      end
   end

   // Writes and sweep clears never coincide: writes are only accepted when idle.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (wr_fire) begin
            mem[wr_addr] <= wr_data;
         end
         if (state == SWEEP) begin
            mem[ptr] <= '0;
         end
      end
   end

   reg_file_read_port #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
      .R0_ZERO(R0_ZERO), .BYPASS(BYPASS)
   ) u_port_a (
      .addr(rd_addr_a), .stored(mem[rd_addr_a]), .wr_fire(wr_fire),
      .wr_addr(wr_addr), .wr_data(wr_data), .data(rd_data_a)
   );

   reg_file_read_port #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
      .R0_ZERO(R0_ZERO), .BYPASS(BYPASS)
   ) u_port_b (
      .addr(rd_addr_b), .stored(mem[rd_addr_b]), .wr_fire(wr_fire),
      .wr_addr(wr_addr), .wr_data(wr_data), .data(rd_data_b)
   );

endmodule

// File: tb/tb_reg_file_sweep.sv
// Directed bench: default 16-entry file with bypass, plus a 12-entry file
// without bypass for out-of-range addresses and non-forwarded reads.
`timescale 1ns/100ps
module tb_reg_file_sweep;
   import reg_file_pkg::*;

   logic        clk;
   logic        clr;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  rd_addr_a;
   logic [31:0] rd_data_a;
   logic [3:0]  rd_addr_b;
   logic [31:0] rd_data_b;
   logic        bulk_clr_req;
   logic        busy;
   logic        wr_drop;
   state_t      fsm_state;

   logic        w2_en;
   logic [3:0]  w2_addr;
   logic [31:0] w2_data;
   logic [3:0]  r2_addr_a;
   logic [31:0] r2_data_a;
   logic [3:0]  r2_addr_b;
   logic [31:0] r2_data_b;
   logic        b2_req;
   logic        busy2;
   logic        drop2;
   state_t      state2;

   int total = 0;
   int bad   = 0;

   reg_file_sweep dut (
      .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
      .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
      .bulk_clr_req(bulk_clr_req), .busy(busy), .wr_drop(wr_drop),
      .fsm_state(fsm_state)
   );

   reg_file_sweep #(.WIDTH(32), .DEPTH(12), .R0_ZERO(1), .BYPASS(0)) dut2 (
      .clk(clk), .clr(clr), .wr_en(w2_en), .wr_addr(w2_addr), .wr_data(w2_data),
      .rd_addr_a(r2_addr_a), .rd_data_a(r2_data_a),
      .rd_addr_b(r2_addr_b), .rd_data_b(r2_data_b),
      .bulk_clr_req(b2_req), .busy(busy2), .wr_drop(drop2),
      .fsm_state(state2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_dut();
      for (int i = 0; i < 16; i++) begin
         wr_en   = 1'b1;
         wr_addr = 4'(i);
         wr_data = 32'(i + 1);
         tick();
      end
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      clr = 1'b0;
      tick();
      tick();
      rd_addr_a = 4'd3;
      r2_addr_a = 4'd3;
      #1;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      total++;
      if (wr_drop !== 1'b0) begin bad++; $display("FAIL reset_drop got=%0b exp=0", wr_drop); end
      total++;
      if (rd_data_a !== 32'd0) begin bad++; $display("FAIL reset_r3 got=%0h exp=0", rd_data_a); end
      total++;
      if (fsm_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
      clr = 1'b1;
      tick();
   endtask

   task automatic test_write();
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'd7; rd_addr_a = 4'd3;
      tick();
      wr_en = 1'b0;
      #1;
      total++;
      if (rd_data_a !== 32'd7) begin bad++; $display("FAIL write_r3 got=%0h exp=7", rd_data_a); end
      total++;
      if (wr_drop !== 1'b0) begin bad++; $display("FAIL write_drop got=%0b exp=0", wr_drop); end
   endtask

   task automatic test_bypass();
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'd56; rd_addr_b = 4'd5;
      #1;
      total++;
      if (rd_data_b !== 32'd56) begin bad++; $display("FAIL bypass_same_cycle got=%0h exp=38", rd_data_b); end
      w2_en = 1'b1; w2_addr = 4'd5; w2_data = 32'd9;
      tick();
      wr_en = 1'b0;
      w2_data = 32'd56; r2_addr_b = 4'd5;
      #1;
      total++;
      if (r2_data_b !== 32'd9) begin bad++; $display("FAIL nobypass_old got=%0h exp=9", r2_data_b); end
      tick();
      w2_en = 1'b0;
      #1;
      total++;
      if (r2_data_b !== 32'd56) begin bad++; $display("FAIL nobypass_new got=%0h exp=38", r2_data_b); end
   endtask

   task automatic test_r0();
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'd15; rd_addr_a = 4'd0;
      #1;
      total++;
      if (rd_data_a !== 32'd0) begin bad++; $display("FAIL r0_no_bypass got=%0h exp=0", rd_data_a); end
      tick();
      wr_en = 1'b0;
      #1;
      total++;
      if (rd_data_a !== 32'd0) begin bad++; $display("FAIL r0_read got=%0h exp=0", rd_data_a); end
      total++;
      if (wr_drop !== 1'b0) begin bad++; $display("FAIL r0_drop got=%0b exp=0", wr_drop); end
   endtask

   task automatic test_out_of_range();
      w2_en = 1'b1; w2_addr = 4'd12; w2_data = 32'd3; r2_addr_a = 4'd12;
      tick();
      w2_en = 1'b0;
      #1;
      total++;
      if (drop2 !== 1'b1) begin bad++; $display("FAIL oor_drop_pulse got=%0b exp=1", drop2); end
      total++;
      if (r2_data_a !== 32'd0) begin bad++; $display("FAIL oor_read got=%0h exp=0", r2_data_a); end
      tick();
      total++;
      if (drop2 !== 1'b0) begin bad++; $display("FAIL oor_drop_end got=%0b exp=0", drop2); end
   endtask

   task automatic test_sweep();
      logic [31:0] exp_b;
      fill_dut();
      rd_addr_a = 4'd1;
      #1;
      total++;
      if (rd_data_a !== 32'd2) begin bad++; $display("FAIL fill_r1 got=%0h exp=2", rd_data_a); end
      bulk_clr_req = 1'b1;
      tick();
      bulk_clr_req = 1'b0;
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL sweep_start_busy got=%0b exp=1", busy); end
      for (int k = 0; k < 16; k++) begin
         tick();
         rd_addr_a = 4'(k);
         rd_addr_b = 4'(k + 1);
         exp_b = (k < 15) ? 32'(k + 2) : 32'd0;
         #1;
         total++;
         if (rd_data_a !== 32'd0) begin bad++; $display("FAIL sweep_cleared k=%0d got=%0h exp=0", k, rd_data_a); end
         total++;
         if (rd_data_b !== exp_b) begin bad++; $display("FAIL sweep_kept k=%0d got=%0h exp=%0h", k, rd_data_b, exp_b); end
         total++;
         if (busy !== (k < 15)) begin bad++; $display("FAIL sweep_busy k=%0d got=%0b exp=%0b", k, busy, (k < 15)); end
      end
   endtask

   task automatic test_sweep_collision();
      int cnt;
      fill_dut();
      bulk_clr_req = 1'b1;
      tick();
      bulk_clr_req = 1'b0;
      cnt = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (!busy) break;
         cnt++;
         if (cyc == 5) begin
            wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'haa;
         end
         if (cyc == 6) begin
            wr_en = 1'b0;
            total++;
            if (wr_drop !== 1'b1) begin bad++; $display("FAIL sweep_wr_drop got=%0b exp=1", wr_drop); end
         end
         bulk_clr_req = (cyc == 8);
         tick();
      end
      bulk_clr_req = 1'b0;
      total++;
      if (cnt !== 16) begin bad++; $display("FAIL sweep_busy_len got=%0d exp=16", cnt); end
      rd_addr_a = 4'd3;
      #1;
      total++;
      if (rd_data_a !== 32'd0) begin bad++; $display("FAIL sweep_wr_not_queued got=%0h exp=0", rd_data_a); end
   endtask

   task automatic test_back_to_back();
      int n;
      wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h99; bulk_clr_req = 1'b1; rd_addr_a = 4'd9;
      tick();
      wr_en = 1'b0; bulk_clr_req = 1'b0;
      #1;
      total++;
      if (rd_data_a !== 32'h99) begin bad++; $display("FAIL b2b_write_first got=%0h exp=99", rd_data_a); end
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%0b exp=1", busy); end
      n = 0;
      while (busy && n < 40) begin
         tick();
         n++;
      end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL b2b_sweep_timeout got=%0b exp=0", busy); end
      total++;
      if (rd_data_a !== 32'd0) begin bad++; $display("FAIL b2b_swept got=%0h exp=0", rd_data_a); end
   endtask

   task automatic test_reset_mid_sweep();
      fill_dut();
      bulk_clr_req = 1'b1;
      tick();
      bulk_clr_req = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      clr = 1'b0;
      rd_addr_a = 4'd7;
      rd_addr_b = 4'd12;
      #1;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%0b exp=0", busy); end
      total++;
      if (rd_data_a !== 32'd0) begin bad++; $display("FAIL rst_mid_r7 got=%0h exp=0", rd_data_a); end
      total++;
      if (rd_data_b !== 32'd0) begin bad++; $display("FAIL rst_mid_r12 got=%0h exp=0", rd_data_b); end
      #1;
      clr = 1'b1;
      wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h44; rd_addr_a = 4'd4;
      tick();
      wr_en = 1'b0;
      #1;
      total++;
      if (rd_data_a !== 32'h44) begin bad++; $display("FAIL rst_mid_new_write got=%0h exp=44", rd_data_a); end
      total++;
      if (wr_drop !== 1'b0) begin bad++; $display("FAIL rst_mid_drop got=%0b exp=0", wr_drop); end
   endtask

   initial begin
      clr = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr_a = '0; rd_addr_b = '0; bulk_clr_req = 1'b0;
      w2_en = 1'b0; w2_addr = '0; w2_data = '0;
      r2_addr_a = '0; r2_addr_b = '0; b2_req = 1'b0;
      test_reset();
      test_write();
      test_bypass();
      test_r0();
      test_out_of_range();
      test_sweep();
      test_sweep_collision();
      test_back_to_back();
      test_reset_mid_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
